// File: rtl/download_word_packer.sv
// download_word_packer: packs the loader's image-region byte stream into 16-bit
// masked words, queues them in a small FIFO and writes them to the memory
// controller over a req/ack handshake. Signals done once the download has ended
// and every queued word has been acknowledged.
// Optional feature: define DOWNLOAD_CHECKSUM_EN to add a 16-bit byte checksum output.
module download_word_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  region_sel,
    input  logic                  wr_8bit,
    input  logic [ADDR_WIDTH:0]   addr_8bit,
    input  logic [7:0]            data_8bit,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data,
    output logic [1:0]            mem_mask,
    input  logic                  mem_ack,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
`ifdef DOWNLOAD_CHECKSUM_EN
   ,output logic [15:0]           checksum
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           data;
        logic [1:0]            mask;
    } word_t;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    // input stage: accepted byte, processed one cycle after the strobe
    logic                  in_vld;
    logic [ADDR_WIDTH:0]   in_addr;
    logic [7:0]            in_data;

    // pending even byte waiting for its odd partner
    logic                  pend_vld;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [7:0]            pend_data;

    // skid holds an unpaired odd byte for one cycle
    logic                  skid_vld;
    word_t                 skid_word;

    // word FIFO
    word_t                 fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_cnt;

    logic                  start, byte_acc, in_odd;
    logic [ADDR_WIDTH-1:0] in_waddr;
    word_t                 pend_word, push_word, head;
    logic                  push, pop, wr_en, fifo_full;
    logic                  pend_ld, pend_clr, skid_ld, flush_go;

    assign start     = ((state == S_IDLE) || (state == S_DONE)) && ioctl_download;
    assign byte_acc  = (state == S_LOAD) && wr_8bit && region_sel;
    assign in_odd    = in_addr[0];
    assign in_waddr  = in_addr[ADDR_WIDTH:1];
    assign pend_word = '{addr: pend_addr, data: {8'h00, pend_data}, mask: 2'b01};
    // flush may only run once no byte is in flight in the input stage or skid
    assign flush_go  = (state == S_FLUSH) && !in_vld && !skid_vld;

    assign fifo_full = (fifo_cnt == (PW + 1)'(FIFO_DEPTH));
    assign pop       = mem_ack && (fifo_cnt != '0);
    assign wr_en     = push && (!fifo_full || pop);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ioctl_download)   state_nxt = S_LOAD;
            S_LOAD:  if (!ioctl_download)  state_nxt = S_FLUSH;
            S_FLUSH: if (flush_go)         state_nxt = S_DRAIN;
            S_DRAIN: if (fifo_cnt == '0)   state_nxt = S_DONE;
            S_DONE:  if (ioctl_download)   state_nxt = S_LOAD;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // packing decisions; a valid skid implies no pending byte, so the skid
    // override below never discards a pending push
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        pend_ld   = 1'b0;
        pend_clr  = 1'b0;
        skid_ld   = 1'b0;
        if (in_vld) begin
            if (!in_odd) begin
                if (pend_vld) begin
                    push      = 1'b1;
                    push_word = pend_word;
                end
                pend_ld = 1'b1;
            end else if (pend_vld && (pend_addr == in_waddr)) begin
                push      = 1'b1;
                push_word = '{addr: in_waddr, data: {in_data, pend_data}, mask: 2'b11};
                pend_clr  = 1'b1;
            end else begin
                if (pend_vld) begin
                    push      = 1'b1;
                    push_word = pend_word;
                end
                pend_clr = 1'b1;
                skid_ld  = 1'b1;
            end
        end
        if (flush_go && pend_vld) begin
            push      = 1'b1;
            push_word = pend_word;
            pend_clr  = 1'b1;
        end
        if (skid_vld) begin
            push      = 1'b1;
            push_word = skid_word;
        end
    end

    // input stage register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_vld  <= 1'b0;
            in_addr <= '0;
            in_data <= '0;
        end else begin
            in_vld <= byte_acc;
            if (byte_acc) begin
                in_addr <= addr_8bit;
                in_data <= data_8bit;
            end
        end
    end

    // pending and skid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            skid_vld  <= 1'b0;
            skid_word <= '0;
        end else if (start) begin
            pend_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (pend_ld) begin
                pend_vld  <= 1'b1;
                pend_addr <= in_waddr;
                pend_data <= in_data;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end
            skid_vld <= skid_ld;
            if (skid_ld)
                skid_word <= '{addr: in_waddr, data: {in_data, 8'h00}, mask: 2'b10};
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};
        end
    end

    // sticky overflow, cleared at download start
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       overflow <= 1'b0;
        else if (start)                  overflow <= 1'b0;
        else if (push && fifo_full && !pop) overflow <= 1'b1;
    end

`ifdef DOWNLOAD_CHECKSUM_EN
    // running sum of accepted bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         checksum <= '0;
        else if (start)    checksum <= '0;
        else if (byte_acc) checksum <= checksum + {8'h00, data_8bit};
    end
`endif

    assign head     = fifo_mem[rd_ptr];
    assign mem_req  = (fifo_cnt != '0);
    assign mem_addr = head.addr;
    assign mem_data = head.data;
    assign mem_mask = head.mask;
    assign busy     = (state == S_LOAD) || (state == S_FLUSH) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_download_word_packer.sv
// Bench for download_word_packer: directed cases plus randomized downloads
// checked against a queue-based word model and an acking scoreboard.
module tb_download_word_packer;

    localparam int D  = 8;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          ioctl_download, region_sel, wr_8bit;
    logic [AW:0]   addr_8bit;
    logic [7:0]    data_8bit;
    logic          mem_req, mem_ack, overflow, busy, done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic [1:0]    mem_mask;
`ifdef DOWNLOAD_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    download_word_packer #(.FIFO_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .region_sel(region_sel), .wr_8bit(wr_8bit), .addr_8bit(addr_8bit),
        .data_8bit(data_8bit), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_mask(mem_mask), .mem_ack(mem_ack),
        .overflow(overflow), .busy(busy), .done(done)
`ifdef DOWNLOAD_CHECKSUM_EN
       ,.checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    m;
    } ew_t;

    ew_t           exp_q[$];
    int            checks = 0, errors = 0, rx_cnt = 0;
    int            ack_mode = 0;   // 0 never, 1 always, 2 random
    logic          mp_vld;
    logic [AW-1:0] mp_a;
    logic [7:0]    mp_d;
    logic [15:0]   cs_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // reference model: one pending even byte, words emitted in issue order
    task automatic model_byte(input logic [AW:0] a, input logic [7:0] d);
        logic [AW-1:0] w;
        w    = a[AW:1];
        cs_m = cs_m + {8'h00, d};
        if (!a[0]) begin
            if (mp_vld) exp_q.push_back('{mp_a, {8'h00, mp_d}, 2'b01});
            mp_vld = 1'b1; mp_a = w; mp_d = d;
        end else if (mp_vld && mp_a == w) begin
            exp_q.push_back('{w, {d, mp_d}, 2'b11});
            mp_vld = 1'b0;
        end else begin
            if (mp_vld) exp_q.push_back('{mp_a, {8'h00, mp_d}, 2'b01});
            mp_vld = 1'b0;
            exp_q.push_back('{w, {d, 8'h00}, 2'b10});
        end
    endtask

    task automatic send_byte(input logic [AW:0] a, input logic [7:0] d, input logic s);
        wr_8bit = 1'b1; addr_8bit = a; data_8bit = d; region_sel = s;
        if (s) model_byte(a, d);
        @(negedge clk);
        wr_8bit = 1'b0; region_sel = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1; mp_vld = 1'b0; cs_m = '0;
        @(negedge clk);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        if (mp_vld) exp_q.push_back('{mp_a, {8'h00, mp_d}, 2'b01});
        mp_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_qempty"}, exp_q.size(), 0);
        check({tag, "_req0"}, {31'd0, mem_req}, 32'd0);
`ifdef DOWNLOAD_CHECKSUM_EN
        check({tag, "_csum"}, {16'd0, checksum}, {16'd0, cs_m});
`endif
    endtask

    // memory-side responder and scoreboard; compares the head it acks
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!reset && mem_req &&
                (ack_mode == 1 || (ack_mode == 2 && $urandom_range(1, 0) == 1))) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {31'd0, mem_req}, 32'd0);
                end else begin
                    ew_t e;
                    logic [15:0] bm;
                    e  = exp_q.pop_front();
                    bm = {{8{e.m[1]}}, {8{e.m[0]}}};
                    check("word_addr", {7'd0, mem_addr}, {7'd0, e.a});
                    check("word_mask", {30'd0, mem_mask}, {30'd0, e.m});
                    check("word_data", {16'd0, mem_data & bm}, {16'd0, e.d & bm});
                end
                rx_cnt++;
                mem_ack = 1'b1;
            end
        end
    end

    initial begin
        int rx0, rq, g, pat, n;
        logic [AW:0] base, a;

        reset = 1'b1; ioctl_download = 1'b0; region_sel = 1'b0; wr_8bit = 1'b0;
        addr_8bit = '0; data_8bit = '0; mp_vld = 1'b0; cs_m = '0;
        repeat (3) @(negedge clk);
        check("rst_req",  {31'd0, mem_req},  32'd0);
        check("rst_busy", {31'd0, busy},     32'd0);
        check("rst_done", {31'd0, done},     32'd0);
        check("rst_ovf",  {31'd0, overflow}, 32'd0);
        check("rst_head", {mem_addr, mem_mask}, 27'd0);
        check("rst_data", {16'd0, mem_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // complete word, latency and head contents
        start_dl();
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_byte(26'd0, 8'h11, 1'b1);
        send_byte(26'd1, 8'h22, 1'b1);
        check("t1_req_early", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("t1_req", {31'd0, mem_req}, 32'd1);
        check("t1_addr", {7'd0, mem_addr}, 32'd0);
        check("t1_data", {16'd0, mem_data}, 32'h2211);
        check("t1_mask", {30'd0, mem_mask}, 32'd3);
        ack_mode = 1;
        end_dl();
        wait_done("t1");

        // flushed partial word
        start_dl();
        send_byte(26'd4, 8'hAA, 1'b1);
        end_dl();
        wait_done("t2");

        // lone odd byte through the skid
        start_dl();
        send_byte(26'd7, 8'h55, 1'b1);
        end_dl();
        wait_done("t3");

`ifdef DOWNLOAD_CHECKSUM_EN
        start_dl();
        send_byte(26'd0, 8'hFF, 1'b1);
        send_byte(26'd1, 8'h02, 1'b1);
        end_dl();
        wait_done("t_cs");
        check("t_cs_val", {16'd0, checksum}, 32'h0101);
`endif

        // overflow: no acks, 2*D+2 bytes -> D+1 words, last one dropped
        ack_mode = 0;
        start_dl();
        for (int i = 0; i < 2 * D; i++) send_byte(26'(i), 8'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        check("t4_ovf_pre", {31'd0, overflow}, 32'd0);
        check("t4_req", {31'd0, mem_req}, 32'd1);
        for (int i = 2 * D; i < 2 * D + 2; i++) send_byte(26'(i), 8'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        void'(exp_q.pop_back());
        rx0 = rx_cnt;
        ack_mode = 1;
        end_dl();
        wait_done("t4");
        check("t4_rx", rx_cnt - rx0, D);
        check("t4_ovf_hold", {31'd0, overflow}, 32'd1);

        // reset mid-stream with three words queued
        ack_mode = 0;
        start_dl();
        check("t5_ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 6; i++) send_byte(26'(100 + i), 8'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        check("t5_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_req",  {31'd0, mem_req}, 32'd0);
        check("t5_rst_busy", {31'd0, busy},    32'd0);
        exp_q.delete(); mp_vld = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ack_mode = 2;
        rq = 0;
        repeat (20) begin @(negedge clk); if (mem_req) rq++; end
        check("t5_noreq", rq, 0);

        // randomized downloads with random acks
        for (int dl = 0; dl < 8; dl++) begin
            pat  = $urandom_range(2, 0);
            base = 26'($urandom);
            start_dl();
            n = $urandom_range(60, 20);
            for (int i = 0; i < n; i++) begin
                g = 0;
                while (exp_q.size() > D - 3 && g < 500) begin @(negedge clk); g++; end
                if (g >= 500) check("guard_timeout", g, 0);
                case (pat)
                    0:       a = base + 26'(i);
                    1:       a = base + 26'($urandom_range(15, 0));
                    default: a = base + 26'(2 * i + 1);
                endcase
                send_byte(a, 8'($urandom), $urandom_range(9, 0) != 0);
                repeat ($urandom_range(2, 0)) @(negedge clk);
            end
            end_dl();
            wait_done("rnd");
            check("rnd_ovf", {31'd0, overflow}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
